// File: rtl/demux18_buf.sv
// 1-to-8 buffered demultiplexer with single-entry valid/ready output buffers.
// Optional per-channel pop counters when DEMUX_CNT_EN is defined.
module demux18_buf #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   in_data,
  input  logic [2:0]     in_sel,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [8*W-1:0] out_data,
  output logic [7:0]     out_valid,
  input  logic [7:0]     out_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [63:0]    cnt_flat
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       state    [8];
  state_t       state_nx [8];
  logic [W-1:0] buf_q    [8];
  logic [7:0]   push;
  logic [7:0]   pop;
  logic         xfer;

  always_comb begin
    in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    xfer     = in_valid & in_ready;
    push     = xfer ? (8'b1 << in_sel) : 8'b0;
    pop      = out_valid & out_ready;
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      state_nx[k] = state[k];
      unique case (state[k])
        EMPTY: if (push[k]) state_nx[k] = FULL;
        FULL:  if (pop[k] && !push[k]) state_nx[k] = EMPTY;
        default: state_nx[k] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (rst) begin
        state[k] <= EMPTY;
        buf_q[k] <= '0;
      end else begin
        state[k] <= state_nx[k];
        if (push[k]) buf_q[k] <= in_data;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      out_valid[k]       = (state[k] == FULL);
      out_data[k*W +: W] = buf_q[k];
    end
  end

`ifdef DEMUX_CNT_EN
  logic [7:0] cnt [8];

  // Counters wrap naturally at 8 bits.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (rst)         cnt[k] <= 8'h00;
      else if (pop[k]) cnt[k] <= cnt[k] + 8'h01;
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) cnt_flat[k*8 +: 8] = cnt[k];
  end
`endif

endmodule
